// File: rtl/rr_dec_arbiter_pkg.sv
// rr_dec_arbiter shared types and constants.
// State encoding, requester count, index width, pointer reset value.
package rr_dec_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  localparam logic [IDX_W-1:0] PTR_RST = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_dec_arbiter_if.sv
// Request/grant bundle between four clients and rr_dec_arbiter.
// master = requester side, slave = arbiter side.
interface rr_dec_arbiter_if
  import rr_dec_arbiter_pkg::*;
  ;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );

endinterface

// File: rtl/rr_dec_arbiter_two_to_four.sv
// two_to_four: enabled 2-to-4 one-hot decoder.
// Pure combinational; Y0 is selected by A1A0 = 00.
module two_to_four (
  input  logic A1,
  input  logic A0,
  input  logic EN,
  output logic Y3,
  output logic Y2,
  output logic Y1,
  output logic Y0
);

  assign Y0 = EN & ~A1 & ~A0;
  assign Y1 = EN & ~A1 &  A0;
  assign Y2 = EN &  A1 & ~A0;
  assign Y3 = EN &  A1 &  A0;

endmodule

// File: rtl/rr_dec_arbiter.sv
// Four-way round-robin arbiter with decoded one-hot grant.
// Optional grant timeout: define RR_DEC_ARBITER_TIMEOUT_EN.
module rr_dec_arbiter
  import rr_dec_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  rr_dec_arbiter_if.slave  io_bus
);

  state_t           r_state;
  state_t           w_state_n;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_n;
  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] w_last_n;
  logic [IDX_W-1:0] w_pick;
  logic             w_release;
  logic             w_valid;

  // First set request scanning last+1, last+2, ... mod 4.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [IDX_W-1:0]   last
  );
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = last + IDX_W'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign w_pick    = rr_pick(io_bus.req, r_last);
  assign w_release = io_bus.done | ~io_bus.req[r_idx];
  assign w_valid   = (r_state == GRANT);

`ifdef RR_DEC_ARBITER_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_n;
  logic       r_timeout;
  logic       w_to;
`else
  logic [7:0] w_unused_hold;
  assign w_unused_hold = 8'(MAX_HOLD);
`endif

  // Next state, winner and pointer selection.
  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_last_n  = r_last;
`ifdef RR_DEC_ARBITER_TIMEOUT_EN
    w_to      = 1'b0;
    w_cnt_n   = (r_state == GRANT) ? r_cnt + 8'd1 : 8'd0;
`endif
    unique case (r_state)
      IDLE: begin
        if (|io_bus.req) begin
          w_state_n = GRANT;
          w_idx_n   = w_pick;
          w_last_n  = w_pick;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_state_n = IDLE;
        end
`ifdef RR_DEC_ARBITER_TIMEOUT_EN
        else if (r_cnt == 8'(MAX_HOLD - 1)) begin
          w_state_n = IDLE;
          w_to      = 1'b1;
        end
`endif
      end
      default: w_state_n = IDLE;
    endcase
  end

  // State, owner index and priority pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_last  <= PTR_RST;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_last  <= w_last_n;
    end
  end

`ifdef RR_DEC_ARBITER_TIMEOUT_EN
  // Hold counter and one-cycle revoke pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_n;
      r_timeout <= w_to;
    end
  end

  assign io_bus.timeout = r_timeout;
`else
  assign io_bus.timeout = 1'b0;
`endif

  assign io_bus.grant_idx   = r_idx;
  assign io_bus.grant_valid = w_valid;

  two_to_four u_dec (
    .A1 (r_idx[1]),
    .A0 (r_idx[0]),
    .EN (w_valid),
    .Y3 (io_bus.grant[3]),
    .Y2 (io_bus.grant[2]),
    .Y1 (io_bus.grant[1]),
    .Y0 (io_bus.grant[0])
  );

endmodule
